ef_pin_in_demux: RTL

- Input-direction companion to the pin multiplexer. Pads feed peripherals through this block.
- Each pad input is synchronised to clk, optionally glitch-filtered, and routed only to the peripheral slot selected by that pin's 2-bit select.
- Unselected slots are driven to a per-slot idle level.
- Filtered pin state, sticky rise/fall flags and a select-change blanking window are provided for the register/interrupt wrapper.

---
 rtl/ef_pin_in_demux.sv | 107 ++++++++++
 1 files changed

// File: rtl/ef_pin_in_demux.sv
// ============================================================================
// Module   : ef_pin_in_demux
// Brief    : Pad-to-peripheral input demux with sync, glitch filter, sticky
//            edge flags and per-pin select-change blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ef_pin_in_demux #(
  parameter int COUNT  = 32,
  parameter int FILT_W = 4,
  parameter int BLANK  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [COUNT-1:0]    io_in,
  input  logic [COUNT-1:0]    sel0,
  input  logic [COUNT-1:0]    sel1,
  input  logic [COUNT*4-1:0]  p_idle,
  output logic [COUNT*4-1:0]  p_in,
  input  logic [COUNT-1:0]    filt_en,
  input  logic [FILT_W-1:0]   filt_len,
  input  logic [COUNT-1:0]    flag_clr,
  output logic [COUNT-1:0]    pin_state,
  output logic [COUNT-1:0]    rise_flag,
  output logic [COUNT-1:0]    fall_flag
);

  localparam int        c_BW       = 8;
  localparam [c_BW-1:0] c_BLANK_LD = c_BW'(BLANK);

  for (genvar gi = 0; gi < COUNT; gi++) begin : g_pin
    logic              r_s1;
    logic              r_s2;
    logic              r_f;
    logic              r_rise;
    logic              r_fall;
    logic [FILT_W-1:0] r_cnt;
    logic [1:0]        r_sel_q;
    logic [c_BW-1:0]   r_blank;

    logic              w_f_next;
    logic [FILT_W-1:0] w_cnt_next;
    logic [1:0]        w_sel;
    logic              w_rise_set;
    logic              w_fall_set;

    assign w_sel = {sel1[gi], sel0[gi]};

    // The counter only advances while the synchronised level disagrees with f;
    // f follows once the disagreement has lasted filt_len+1 compares.
    always_comb begin
      w_f_next   = r_f;
      w_cnt_next = '0;
      if (!filt_en[gi]) begin
        w_f_next = r_s2;
      end else if (r_s2 != r_f) begin
        if (r_cnt < filt_len) begin
          w_cnt_next = r_cnt + FILT_W'(1);
        end else begin
          w_f_next = r_s2;
        end
      end
    end

    assign w_rise_set = w_f_next & ~r_f;
    assign w_fall_set = ~w_f_next & r_f;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_f     <= 1'b0;
        r_cnt   <= '0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_sel_q <= 2'b00;
        r_blank <= '0;
      end else begin
        r_s1    <= io_in[gi];
        r_s2    <= r_s1;
        r_f     <= w_f_next;
        r_cnt   <= w_cnt_next;
        r_rise  <= w_rise_set | (r_rise & ~flag_clr[gi]);
        r_fall  <= w_fall_set | (r_fall & ~flag_clr[gi]);
        r_sel_q <= w_sel;
        if (w_sel != r_sel_q) begin
          r_blank <= c_BLANK_LD;
        end else if (r_blank != '0) begin
          r_blank <= r_blank - c_BW'(1);
        end
      end
    end

    assign pin_state[gi] = r_f;
    assign rise_flag[gi] = r_rise;
    assign fall_flag[gi] = r_fall;

    for (genvar gk = 0; gk < 4; gk++) begin : g_slot
      assign p_in[gi*4+gk] = ((r_sel_q == 2'(gk)) && (r_blank == '0))
                             ? r_f : p_idle[gi*4+gk];
    end
  end

endmodule

`default_nettype wire
